// File: rtl/regfile_dump_controller.sv
// rtl/regfile_dump_controller.sv - register file dump/clear sequencer for core debug and bring-up
//
// Walks the register file through read port 1 and streams each value out over a
// valid/ready handshake (dump), or writes zero to R0..min(LAST_REG,14) through the
// write port (clear). The core is stalled for the whole command.
//
// Ports:
//   clk, rst_n        clock shared with the register file, async active-low reset
//   start, clear_mode command strobe and mode (0 = dump, 1 = clear), sampled in IDLE
//   busy, cpu_stall   high whenever a command is in progress
//   done              one-cycle pulse at the end of a command
//   rf_we/a3/wd       register file write port
//   rf_a1, rf_rd1     register file read port 1 (combinational read)
//   dump_valid/ready  stream handshake
//   dump_index/data   register index and captured value of the current beat
module regfile_dump_controller #(
  parameter int LAST_REG = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clear_mode,
  output logic        busy,
  output logic        cpu_stall,
  output logic        done,
  output logic        rf_we,
  output logic [3:0]  rf_a1,
  output logic [3:0]  rf_a3,
  output logic [31:0] rf_wd,
  input  logic [31:0] rf_rd1,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [3:0]  dump_index,
  output logic [31:0] dump_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // R15 reads as PC+8 and cannot be written, so clear stops at R14 at most.
  localparam int         CLR_LAST_I = (LAST_REG > 14) ? 14 : LAST_REG;
  localparam logic [3:0] CLR_LAST   = 4'(CLR_LAST_I);
  localparam logic [3:0] DUMP_LAST  = 4'(LAST_REG);

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] dump_data_q, dump_data_d;
  logic [3:0]  dump_index_q, dump_index_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dump_data_d  = dump_data_q;
    dump_index_d = dump_index_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = 4'd0;
          state_d = clear_mode ? S_CLEAR : S_READ;
        end
      end
      S_CLEAR: begin
        // Terminal compare before the increment keeps idx from ever wrapping.
        if (idx_q == CLR_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_READ: begin
        dump_data_d  = rf_rd1;
        dump_index_d = idx_q;
        state_d      = S_OUT;
      end
      S_OUT: begin
        if (dump_ready) begin
          if (idx_q == DUMP_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= 4'd0;
      dump_data_q  <= 32'd0;
      dump_index_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dump_data_q  <= dump_data_d;
      dump_index_q <= dump_index_d;
    end
  end

  // All outputs decode registered state only; an async reset forces IDLE and so
  // drops rf_we immediately.
  assign busy       = (state_q != S_IDLE);
  assign cpu_stall  = busy;
  assign done       = (state_q == S_DONE);
  assign rf_we      = (state_q == S_CLEAR);
  assign rf_a3      = rf_we ? idx_q : 4'd0;
  assign rf_wd      = 32'd0;
  assign rf_a1      = ((state_q == S_READ) || (state_q == S_OUT)) ? idx_q : 4'd0;
  assign dump_valid = (state_q == S_OUT);
  assign dump_index = dump_index_q;
  assign dump_data  = dump_data_q;

endmodule

// File: tb/tb_regfile_dump_controller.sv
// tb/tb_regfile_dump_controller.sv - self-checking bench for regfile_dump_controller
module tb_regfile_dump_controller;

  localparam int LAST_REG = 15;
  localparam int CLR_N    = (LAST_REG > 14) ? 15 : LAST_REG + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear_mode = 1'b0;
  logic        dump_ready = 1'b0;
  logic        busy, cpu_stall, done, rf_we, dump_valid;
  logic [3:0]  rf_a1, rf_a3, dump_index;
  logic [31:0] rf_wd, rf_rd1, dump_data;

  // Register file environment: R0..R14 storage, R15 is an external PC+8 value.
  logic [31:0] rf_mem [16];
  logic [31:0] r15_val = 32'd0;
  logic        tb_we = 1'b0;
  logic [3:0]  tb_addr = 4'd0;
  logic [31:0] tb_wdata = 32'd0;

  assign rf_rd1 = (rf_a1 == 4'd15) ? r15_val : rf_mem[rf_a1];

  regfile_dump_controller #(.LAST_REG(LAST_REG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_mode(clear_mode),
    .busy(busy), .cpu_stall(cpu_stall), .done(done),
    .rf_we(rf_we), .rf_a1(rf_a1), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_rd1(rf_rd1),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_index(dump_index), .dump_data(dump_data)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Transaction-level model: a command becomes a list of expected beats (dump)
  // or writes (clear); done is due the cycle after the list is exhausted.
  logic        m_busy = 1'b0;
  logic        m_clear = 1'b0;
  logic        m_done_now = 1'b0;
  logic        was_busy;
  int          m_head = 0;
  int          m_count = 0;
  int          m_cyc = 0;
  int          m_beats = 0;
  logic [3:0]  exp_idx [16];
  logic [31:0] exp_data [16];

  // Observations handed from the negedge compare to the posedge model.
  logic        p_start = 1'b0, p_mode = 1'b0, p_pop = 1'b0, p_wr = 1'b0;
  logic [3:0]  p_wa = 4'd0;
  logic [31:0] p_wd = 32'd0;
  int          done_cnt = 0;
  int          obs_done_cyc = -1;
  logic        ready_rand = 1'b0;

  initial begin
    for (int k = 0; k < 16; k++) rf_mem[k] = 32'd0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0;
        m_done_now = 1'b0;
        m_head = 0;
        m_count = 0;
      end else begin
        if (p_wr) rf_mem[p_wa] <= p_wd;
        if (tb_we) rf_mem[tb_addr] <= tb_wdata;
        was_busy = m_busy;
        if (m_busy) m_cyc++;
        if (m_done_now) begin
          m_done_now = 1'b0;
          m_busy = 1'b0;
        end else if (p_pop && m_head < m_count) begin
          m_head++;
          if (!m_clear) m_beats++;
          if (m_head == m_count) m_done_now = 1'b1;
        end
        if (!was_busy && p_start) begin
          m_busy = 1'b1;
          m_clear = p_mode;
          m_head = 0;
          m_cyc = 1;
          m_count = p_mode ? CLR_N : LAST_REG + 1;
          for (int k = 0; k < 16; k++) begin
            exp_idx[k]  = 4'(k);
            exp_data[k] = p_mode ? 32'd0 : ((k == 15) ? r15_val : rf_mem[k]);
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    p_start = 1'b0;
    p_pop = 1'b0;
    p_wr = 1'b0;
    if (rst_n) begin
      p_start = start;
      p_mode  = clear_mode;
      chk("busy", busy, m_busy);
      chk("cpu_stall", cpu_stall, m_busy);
      chk("done", done, m_done_now);
      if (done) begin
        done_cnt++;
        obs_done_cyc = m_cyc;
      end
      chk("rf_we", rf_we, m_busy & m_clear & ~m_done_now);
      chk("dump_valid_allowed", dump_valid & ~(m_busy & ~m_clear & ~m_done_now), 0);
      if (!m_busy) chk("rf_a1_idle", rf_a1, 0);
      if (rf_we) begin
        p_wr = 1'b1;
        p_wa = rf_a3;
        p_wd = rf_wd;
        if (m_head < m_count) begin
          chk("rf_a3", rf_a3, exp_idx[m_head]);
          chk("rf_wd", rf_wd, 0);
          p_pop = 1'b1;
        end else fail("extra_write");
      end else begin
        chk("rf_a3_idle", rf_a3, 0);
        chk("rf_wd_idle", rf_wd, 0);
      end
      if (dump_valid) begin
        if (m_head < m_count) begin
          chk("dump_index", dump_index, exp_idx[m_head]);
          chk("dump_data", dump_data, exp_data[m_head]);
          chk("rf_a1_out", rf_a1, exp_idx[m_head]);
          if (dump_ready) p_pop = 1'b1;
        end else fail("extra_beat");
      end
    end
  end

  // Random backpressure driver, enabled per test.
  initial forever begin
    @(posedge clk);
    #1;
    if (ready_rand) dump_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic mode);
    start = 1'b1;
    clear_mode = mode;
    cyc(1);
    start = 1'b0;
    clear_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (m_busy && n < 600) begin
      cyc(1);
      n++;
    end
    if (m_busy) fail(name);
    cyc(1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    tb_we = 1'b1;
    tb_addr = a;
    tb_wdata = d;
    cyc(1);
    tb_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_stall"}, cpu_stall, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_we"}, rf_we, 0);
    chk({tag, "_valid"}, dump_valid, 0);
    chk({tag, "_a1"}, rf_a1, 0);
    chk({tag, "_a3"}, rf_a3, 0);
    chk({tag, "_wd"}, rf_wd, 0);
    chk({tag, "_index"}, dump_index, 0);
    chk({tag, "_data"}, dump_data, 0);
  endtask

  logic [31:0] saved [16];
  int d0, b0, n;
  logic [31:0] acc;

  initial begin
    // Reset values.
    cyc(3);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    cyc(2);
    check_reset_outputs("after_reset");

    // Dump sequence with LAST_REG=15 and ready held high.
    wr(4'd0, 32'hFF);
    wr(4'd1, 32'hF0);
    wr(4'd2, $urandom);
    wr(4'd3, 32'hF);
    for (int k = 4; k < 15; k++) wr(4'(k), $urandom);
    r15_val = 32'd20;
    dump_ready = 1'b1;
    d0 = done_cnt;
    obs_done_cyc = -1;
    pulse_start(1'b0);
    chk("model_count", m_count, 16);
    chk("model_d0", exp_data[0], 32'hFF);
    chk("model_d1", exp_data[1], 32'hF0);
    chk("model_d3", exp_data[3], 32'hF);
    chk("model_d15", exp_data[15], 32'd20);
    wait_idle("dump_timeout");
    chk("dump_done_cycle", obs_done_cyc, 33);
    chk("dump_done_once", done_cnt - d0, 1);

    // Backpressure on index 1.
    pulse_start(1'b0);
    n = 0;
    while (!(dump_valid && dump_index == 4'd1) && n < 20) begin
      cyc(1);
      n++;
    end
    if (n >= 20) fail("bp_reach_index1");
    dump_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", dump_valid, 1);
      chk("bp_index", dump_index, 1);
      chk("bp_data", dump_data, 32'hF0);
      cyc(1);
    end
    dump_ready = 1'b1;
    wait_idle("bp_timeout");

    // Clear, then dump back zeros.
    for (int k = 0; k < 15; k++) wr(4'(k), $urandom | 32'h1);
    obs_done_cyc = -1;
    pulse_start(1'b1);
    chk("clear_model_count", m_count, 15);
    wait_idle("clear_timeout");
    chk("clear_done_cycle", obs_done_cyc, 16);
    acc = 32'd0;
    for (int k = 0; k < 15; k++) acc = acc | rf_mem[k];
    chk("clear_regs_zero", acc, 0);
    pulse_start(1'b0);
    acc = 32'd0;
    for (int k = 0; k < 15; k++) acc = acc | exp_data[k];
    chk("model_zero_snapshot", acc, 0);
    wait_idle("dump_zero_timeout");

    // Ignored start during an active dump, random backpressure.
    for (int k = 0; k < 15; k++) wr(4'(k), $urandom);
    ready_rand = 1'b1;
    d0 = done_cnt;
    b0 = m_beats;
    pulse_start(1'b0);
    cyc(4);
    pulse_start(1'b1);
    cyc(7);
    pulse_start(1'b0);
    wait_idle("ignored_start_timeout");
    chk("ignored_start_beats", m_beats - b0, 16);
    chk("ignored_start_done", done_cnt - d0, 1);

    // Randomized commands.
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 3; k++) wr(4'($urandom_range(0, 14)), $urandom);
      r15_val = $urandom;
      d0 = done_cnt;
      b0 = m_beats;
      if ($urandom_range(0, 1) == 1) begin
        pulse_start(1'b1);
        wait_idle("rand_clear_timeout");
        acc = 32'd0;
        for (int k = 0; k < 15; k++) acc = acc | rf_mem[k];
        chk("rand_clear_zero", acc, 0);
      end else begin
        pulse_start(1'b0);
        wait_idle("rand_dump_timeout");
        chk("rand_dump_beats", m_beats - b0, 16);
      end
      chk("rand_done", done_cnt - d0, 1);
    end

    // Back-to-back: start in the IDLE cycle right after DONE.
    ready_rand = 1'b0;
    dump_ready = 1'b1;
    pulse_start(1'b0);
    n = 0;
    while (!m_done_now && n < 100) begin
      cyc(1);
      n++;
    end
    if (n >= 100) fail("b2b_done_timeout");
    cyc(1);
    obs_done_cyc = -1;
    pulse_start(1'b1);
    wait_idle("b2b_clear_timeout");
    chk("b2b_clear_done_cycle", obs_done_cyc, 16);

    // Reset in the middle of a clear at idx 5.
    for (int k = 0; k < 15; k++) begin
      saved[k] = $urandom | 32'h1;
      wr(4'(k), saved[k]);
    end
    d0 = done_cnt;
    pulse_start(1'b1);
    n = 0;
    while (!(rf_we && rf_a3 == 4'd5) && n < 30) begin
      cyc(1);
      n++;
    end
    if (n >= 30) fail("reset_reach_idx5");
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rf_we", rf_we, 0);
    chk("async_busy", busy, 0);
    chk("async_stall", cpu_stall, 0);
    chk("async_done", done, 0);
    chk("async_a3", rf_a3, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    chk("reset_no_done", done_cnt - d0, 0);
    chk("reset_idle", busy, 0);
    acc = 32'd0;
    for (int k = 0; k < 5; k++) acc = acc | rf_mem[k];
    chk("reset_r0_r4_cleared", acc, 0);
    for (int k = 5; k < 15; k++) chk("reset_untouched", rf_mem[k], saved[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_dump_controller.md
# regfile_dump_controller

Sequencer that drives the register file's read/write port pins from the other side of the interface. It serves debug and bring-up of the single-cycle ARM core. On command it either walks the registers through read port 1 and streams each value out over a valid/ready handshake, or clears R0..R14 to zero through the write port. While active it asserts a stall to the core so the core's writeback never competes for the register file.

## Interface
Parameters:
- LAST_REG, 14: highest register index visited. Legal range 1..15.
  - 15 includes the R15 (PC+8) value in a dump.
  - Clear mode never writes above 14.

Ports:
- clk  in  1  rising-edge clock, shared with the register file.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- clear_mode  in  1  sampled with start: 0 = dump, 1 = clear.
- busy  out  1  high whenever state is not IDLE.
- cpu_stall  out  1  equals busy; the core must suppress WE while high.
- done  out  1  one-cycle pulse at the end of a command.
- rf_we  out  1  register file write enable.
- rf_a1  out  4  read port 1 address.
- rf_a3  out  4  write address.
- rf_wd  out  32  write data.
- rf_rd1  in  32  read port 1 data (combinational read in the register file).
- dump_valid  out  1  stream data valid.
- dump_ready  in  1  stream consumer ready.
- dump_index  out  4  register index of the current dump_data.
- dump_data  out  32  captured register value.

## Operation
States: IDLE, CLEAR, READ, OUT, DONE. Internal 4-bit index idx.

- **IDLE**
  - start=1 with clear_mode=0 → READ, idx=0.
  - start=1 with clear_mode=1 → CLEAR, idx=0.
  - start=0 → stay in IDLE.
- **CLEAR**
  - Outputs: rf_we=1, rf_a3=idx, rf_wd=0.
  - Each cycle: if idx==min(LAST_REG,14) → DONE, else idx+1.
- **READ**
  - Output: rf_a1=idx.
  - At the clock edge: dump_data←rf_rd1, dump_index←idx, → OUT.
- **OUT**
  - Outputs: dump_valid=1; dump_data and dump_index held stable.
  - Handshake = dump_valid & dump_ready at a rising edge.
  - On handshake: if idx==LAST_REG → DONE, else idx+1 → READ.
  - Without handshake: stay in OUT, no change to any output.
- **DONE**
  - Output: done=1 for exactly one cycle.
  - Next state IDLE; idx reset to 0.

Output rules:
- rf_we=1 only in CLEAR. rf_a3 and rf_wd are 0 in all other states.
- rf_a1=idx in READ and OUT, 0 otherwise.
- start or clear_mode changes while busy are ignored. No queuing.
- idx never wraps. The terminal compare happens before the increment, so LAST_REG=15 terminates without overflow.

## Timing
Reset (rst_n=0, asynchronous):
- state=IDLE, idx=0.
- busy, cpu_stall, done, rf_we, dump_valid = 0.
- rf_a1, rf_a3, rf_wd, dump_index, dump_data = 0.
- Reset mid-command aborts immediately. rf_we falls without waiting for a clock edge. No done pulse is produced. After release, a new start is required.

State and outputs:
- All state changes occur on the rising clk edge.
- Outputs are decoded from registered state, idx and data, so they carry no combinational path from start.
- dump_valid, dump_index and dump_data have no combinational path from dump_ready.

Latency, measured from the start edge:
- busy rises on cycle 1.
- Dump: each register costs 1 READ cycle plus ≥1 OUT cycle.
  - With dump_ready held high, LAST_REG=14 finishes in 30 cycles.
  - done is then high in cycle 31; busy falls in cycle 32.
- Clear: (min(LAST_REG,14)+1) write cycles.
  - Default: 15 write cycles, done in cycle 16.
  - Each write commits at the rising edge that ends its cycle.
- Back-to-back: start sampled in the cycle after DONE (IDLE) is accepted.

## Test plan
- **Reset values:** hold rst_n=0, then release → all outputs 0 and busy=0 before any start.
- **Dump sequence:** preload R0=0xFF, R1=0xF0, R3=0xF and R15 input=20. Pulse start with clear_mode=0, LAST_REG=15, dump_ready=1.
  - Required: 16 beats with indices 0..15 and data 0xFF, 0xF0, x, 0xF, …, 20.
  - done pulses exactly once; cpu_stall is high throughout.
- **Backpressure:** hold dump_ready=0 for 5 cycles on index 1.
  - Required: dump_valid stays 1, dump_index stays 1 and dump_data stays 0xF0, unchanged.
  - After ready rises: exactly one beat at index 1, then index 2 follows.
- **Clear:** preload nonzero values, then start with clear_mode=1.
  - Required: 15 consecutive rf_we cycles with rf_a3=0..14 and rf_wd=0; done in cycle 16.
  - A following dump reads all zeros for R0..R14.
- **Ignored start:** pulse start during an active dump. Required: sequence and beat count are unchanged.
- **Reset mid-command:** assert rst_n=0 during CLEAR at idx=5. Required: rf_we drops asynchronously, no done pulse, R6..R14 are untouched, state=IDLE.
